// File: rtl/joy_serial_reader_pkg.sv
// Shared types and constants for the DB15 serial joystick reader.
package joy_serial_pkg;

    // FSM state encoding (kept as plain constants for legacy tooling)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD     = 3'd1;
    localparam state_t ST_SHIFT_LO = 3'd2;
    localparam state_t ST_SHIFT_HI = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
    localparam state_t ST_GAP      = 3'd5;

    // Width of one player's slot in the joystick bus
    localparam int unsigned JOY_WORD_W = 16;

    // Standard button bit indices within a player word
    localparam int unsigned BIT_R     = 0;
    localparam int unsigned BIT_L     = 1;
    localparam int unsigned BIT_D     = 2;
    localparam int unsigned BIT_U     = 3;
    localparam int unsigned BIT_A     = 4;
    localparam int unsigned BIT_B     = 5;
    localparam int unsigned BIT_C     = 6;
    localparam int unsigned BIT_X     = 7;
    localparam int unsigned BIT_Y     = 8;
    localparam int unsigned BIT_Z     = 9;
    localparam int unsigned BIT_START = 10;
    localparam int unsigned BIT_MODE  = 11;

endpackage

// File: rtl/joy_serial_reader_if.sv
// User-port pins plus the decoded joystick bus of the serial reader.
interface joy_serial_reader_if #(
    parameter int unsigned PLAYERS = 2
);
    logic                    en;
    logic                    joy_data;
    logic                    joy_clk;
    logic                    joy_load;
    logic [PLAYERS*16-1:0]   joystick;
    logic [PLAYERS-1:0]      connected;
    logic                    frame_valid;

    // Reader side: drives the adaptor chain and publishes decoded words
    modport master (
        input  en, joy_data,
        output joy_clk, joy_load, joystick, connected, frame_valid
    );

    // Environment side: pins and downstream joystick mux
    modport slave (
        output en, joy_data,
        input  joy_clk, joy_load, joystick, connected, frame_valid
    );
endinterface

// File: rtl/joy_serial_reader_tick.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module joy_tick_gen #(
    parameter int unsigned CLK_DIV = 24
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Wrap the counter and flag the wrap cycle
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter and tick registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/joy_serial_reader.sv
// Scans daisy-chained DB15 shift-register adaptors and publishes per-player words.
module joy_serial_reader
    import joy_serial_pkg::*;
#(
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned BITS       = 12,
    parameter int unsigned CLK_DIV    = 24,
    parameter int unsigned LOAD_TICKS = 2,
    parameter int unsigned GAP_TICKS  = 64,
    parameter int unsigned FILTER     = 1
) (
    input  logic              clk,
    input  logic              reset,
    joy_serial_reader_if.master bus
);
    localparam int unsigned NBITS = PLAYERS * BITS;
    localparam int unsigned IW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned TMAX  = (LOAD_TICKS > GAP_TICKS) ? LOAD_TICKS : GAP_TICKS;
    localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned JW    = PLAYERS * JOY_WORD_W;

    logic tick;

    state_t             state_q, state_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [IW-1:0]      bidx_q, bidx_d;
    logic [NBITS-1:0]   raw_q, raw_d;
    logic [NBITS-1:0]   prev_q, prev_d;
    logic [JW-1:0]      joy_q, joy_d;
    logic [PLAYERS-1:0] conn_q, conn_d;
    logic               fv_q, fv_d;
    logic               jclk_q, jclk_d;
    logic               jload_q, jload_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [BITS-1:0]    word_c;
    logic [BITS-1:0]    agree_c;

    joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (reset),
        .tick (tick)
    );

    // Frame sequencer, sampling and the end-of-frame output update
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bidx_d  = bidx_q;
        raw_d   = raw_q;
        prev_d  = prev_q;
        joy_d   = joy_q;
        conn_d  = conn_q;
        fv_d    = 1'b0;
        jclk_d  = jclk_q;
        jload_d = jload_q;
        sync1_d = bus.joy_data;
        sync2_d = sync1_q;
        word_c  = '0;
        agree_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (tick && bus.en) begin
                    jload_d = 1'b0;
                    tcnt_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    if (tcnt_q == TW'(LOAD_TICKS - 1)) begin
                        jload_d = 1'b1;
                        bidx_d  = '0;
                        state_d = ST_SHIFT_LO;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    jclk_d  = 1'b0;
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    raw_d[bidx_q] = ~sync2_q;
                    jclk_d        = 1'b1;
                    if (bidx_q == IW'(NBITS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        bidx_d  = bidx_q + IW'(1);
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_DONE: begin
                // All-ones means a dead chain: drop the player and its history
                for (int unsigned p = 0; p < PLAYERS; p++) begin
                    word_c  = raw_q[p*BITS +: BITS];
                    agree_c = ~(word_c ^ prev_q[p*BITS +: BITS]);
                    if (&word_c) begin
                        conn_d[p]                    = 1'b0;
                        joy_d[p*JOY_WORD_W +: JOY_WORD_W] = '0;
                        prev_d[p*BITS +: BITS]       = '0;
                    end else begin
                        conn_d[p] = 1'b1;
                        if (FILTER != 0) begin
                            joy_d[p*JOY_WORD_W +: BITS] = (joy_q[p*JOY_WORD_W +: BITS] & ~agree_c)
                                                        | (word_c & agree_c);
                            prev_d[p*BITS +: BITS]     = word_c;
                        end else begin
                            joy_d[p*JOY_WORD_W +: BITS] = word_c;
                        end
                    end
                end
                fv_d    = 1'b1;
                tcnt_d  = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tick) begin
                    if (tcnt_q == TW'(GAP_TICKS - 1)) begin
                        tcnt_d = '0;
                        if (bus.en) begin
                            jload_d = 1'b0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and pin registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bidx_q  <= '0;
            raw_q   <= '0;
            prev_q  <= '0;
            joy_q   <= '0;
            conn_q  <= '0;
            fv_q    <= 1'b0;
            jclk_q  <= 1'b1;
            jload_q <= 1'b1;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            raw_q   <= raw_d;
            prev_q  <= prev_d;
            joy_q   <= joy_d;
            conn_q  <= conn_d;
            fv_q    <= fv_d;
            jclk_q  <= jclk_d;
            jload_q <= jload_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign bus.joy_clk     = jclk_q;
    assign bus.joy_load    = jload_q;
    assign bus.joystick    = joy_q;
    assign bus.connected   = conn_q;
    assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench: two readers (FILTER=0 and FILTER=1) fed by adaptor-chain models.
module tb_joy_serial_reader;
    import joy_serial_pkg::*;

    localparam int unsigned PLAYERS    = 2;
    localparam int unsigned BITS       = 12;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned LOAD_TICKS = 2;
    localparam int unsigned GAP_TICKS  = 8;
    localparam int unsigned NB         = PLAYERS * BITS;
    localparam int          PERIOD     = 232;

    localparam logic [BITS-1:0] P0_A = BITS'((1 << BIT_R) | (1 << BIT_D));
    localparam logic [BITS-1:0] P0_B = BITS'((1 << BIT_R) | (1 << BIT_D) | (1 << BIT_A));
    localparam logic [BITS-1:0] P0_C = BITS'((1 << BIT_R) | (1 << BIT_D) | (1 << BIT_C));
    localparam logic [BITS-1:0] P1_A = BITS'((1 << BIT_A) | (1 << BIT_MODE));

    logic clk = 1'b0;
    logic reset;
    logic en = 1'b0;
    logic stuck = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [NB-1:0]         dir_tbl [8];
    logic [1:0]            jclk_w, jload_w, fv_w;
    logic [PLAYERS*16-1:0] joy_w  [2];
    logic [PLAYERS-1:0]    conn_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        joy_serial_reader_if #(.PLAYERS(PLAYERS)) bus ();

        logic [NB-1:0]          sh = '0;
        logic [NB-1:0]          pat_v;
        logic [NB-1:0]          last_pat = '0;
        logic [NB-1:0]          raw_v;
        logic [BITS-1:0]        word_v;
        logic [NB-1:0]          sent_q [$];
        logic [15:0]            m_joy  [PLAYERS];
        logic [BITS-1:0]        m_prev [PLAYERS];
        logic [PLAYERS-1:0]     m_conn = '0;
        logic [PLAYERS*16-1:0]  exp_joy;
        logic [PLAYERS*16-1:0]  last_joy = '0;
        logic [PLAYERS-1:0]     last_conn = '0;
        int frame_no = 0;
        int lo_run = 0, clk_run = 0, clk_pulses = 0, last_fv = -1;
        bit en_gap = 1'b1;

        assign bus.en       = en;
        assign bus.joy_data = stuck ? 1'b0 : ~sh[0];
        assign jclk_w[g]    = bus.joy_clk;
        assign jload_w[g]   = bus.joy_load;
        assign fv_w[g]      = bus.frame_valid;
        assign joy_w[g]     = bus.joystick;
        assign conn_w[g]    = bus.connected;

        joy_serial_reader #(
            .PLAYERS(PLAYERS), .BITS(BITS), .CLK_DIV(CLK_DIV),
            .LOAD_TICKS(LOAD_TICKS), .GAP_TICKS(GAP_TICKS), .FILTER(g)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // Adaptor chain: parallel latch while LOAD low, shift on CLK rise
        always @(negedge bus.joy_load) begin
            if (frame_no < 8) pat_v = dir_tbl[frame_no];
            else if ($urandom_range(1, 0) == 1) pat_v = last_pat;
            else begin
                pat_v = NB'($urandom);
                if ($urandom_range(5, 0) == 0) pat_v[BITS-1:0] = '1;
            end
            frame_no++;
            last_pat = pat_v;
            sh       = pat_v;
            sent_q.push_back(stuck ? {NB{1'b1}} : pat_v);
        end

        always @(posedge bus.joy_clk) if (bus.joy_load) sh = sh >> 1;

        // Reference model, pin timing and scoreboard
        always @(negedge clk) begin
            if (reset) begin
                sent_q.delete();
                for (int p = 0; p < PLAYERS; p++) begin
                    m_joy[p] = '0; m_prev[p] = '0;
                end
                m_conn = '0; lo_run = 0; clk_run = 0; clk_pulses = 0;
                last_fv = -1; en_gap = 1'b1; last_joy = '0; last_conn = '0;
            end else begin
                if (!en) en_gap = 1'b1;
                if (!bus.joy_load) lo_run++;
                else if (lo_run != 0) begin
                    check_eq($sformatf("load_low_clks[f%0d]", g), lo_run, LOAD_TICKS * CLK_DIV);
                    lo_run = 0;
                end
                if (!bus.joy_clk) clk_run++;
                else if (clk_run != 0) begin
                    check_eq($sformatf("clk_low_clks[f%0d]", g), clk_run, CLK_DIV);
                    clk_run = 0;
                    clk_pulses++;
                end
                if (bus.frame_valid) begin
                    check_eq($sformatf("clk_pulses[f%0d]", g), clk_pulses, NB);
                    clk_pulses = 0;
                    if (last_fv >= 0 && !en_gap)
                        check_eq($sformatf("frame_period[f%0d]", g), cyc - last_fv, PERIOD);
                    last_fv = cyc;
                    en_gap  = 1'b0;
                    if (sent_q.size() == 0) begin
                        check_eq($sformatf("sb_underflow[f%0d]", g), sent_q.size(), 1);
                    end else begin
                        raw_v = sent_q.pop_front();
                        for (int p = 0; p < PLAYERS; p++) begin
                            word_v = raw_v[p*BITS +: BITS];
                            if (word_v == {BITS{1'b1}}) begin
                                m_conn[p] = 1'b0; m_joy[p] = '0; m_prev[p] = '0;
                            end else begin
                                m_conn[p] = 1'b1;
                                if (g == 1) begin
                                    for (int b = 0; b < BITS; b++)
                                        if (word_v[b] == m_prev[p][b]) m_joy[p][b] = word_v[b];
                                    m_prev[p] = word_v;
                                end else begin
                                    m_joy[p] = 16'(word_v);
                                end
                            end
                            exp_joy[p*16 +: 16] = m_joy[p];
                        end
                        check_eq($sformatf("joystick[f%0d]", g), bus.joystick, exp_joy);
                        check_eq($sformatf("connected[f%0d]", g), bus.connected, m_conn);
                    end
                end else if (bus.joystick !== last_joy || bus.connected !== last_conn) begin
                    check_eq($sformatf("change_without_fv[f%0d]", g), bus.frame_valid, 1);
                end
                last_joy  = bus.joystick;
                last_conn = bus.connected;
            end
        end
    end

    task automatic wait_fv(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < (n + 4) * PERIOD) begin
            @(negedge clk);
            budget++;
            if (fv_w[0]) seen++;
        end
        if (seen != n) check_eq("fv_timeout", seen, n);
    endtask

    task automatic wait_clk_falls(input int n);
        int   seen = 0;
        int   budget = 0;
        logic prev = 1'b1;
        while (seen < n && budget < 2 * PERIOD) begin
            @(negedge clk);
            budget++;
            if (prev && !jclk_w[0]) seen++;
            prev = jclk_w[0];
        end
        if (seen != n) check_eq("clk_fall_timeout", seen, n);
    endtask

    task automatic check_idle_pins(input string tag);
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("%s_joy_clk[f%0d]", tag, g), jclk_w[g], 1'b1);
            check_eq($sformatf("%s_joy_load[f%0d]", tag, g), jload_w[g], 1'b1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_idle_pins(tag);
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("%s_joystick[f%0d]", tag, g), joy_w[g], 0);
            check_eq($sformatf("%s_connected[f%0d]", tag, g), conn_w[g], 0);
            check_eq($sformatf("%s_fv[f%0d]", tag, g), fv_w[g], 0);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] j0, input logic [31:0] j1,
                               input logic [1:0] c);
        check_eq({tag, "_joy_f0"}, joy_w[0], j0);
        check_eq({tag, "_joy_f1"}, joy_w[1], j1);
        check_eq({tag, "_conn_f0"}, conn_w[0], c);
        check_eq({tag, "_conn_f1"}, conn_w[1], c);
    endtask

    initial begin
        int   fv_seen;
        logic load_fell;
        reset = 1'b1;
        dir_tbl[0] = {P1_A, P0_A};
        dir_tbl[1] = {P1_A, P0_A};
        dir_tbl[2] = {P1_A, P0_B};
        dir_tbl[3] = {P1_A, P0_A};
        dir_tbl[4] = {P1_A, P0_C};
        dir_tbl[5] = {P1_A, P0_C};
        dir_tbl[6] = {{BITS{1'b1}}, P0_C};
        dir_tbl[7] = {{BITS{1'b1}}, P0_C};
        en = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Directed frames: raw decode and two-frame filter behaviour
        wait_fv(1); check_frame("frame0", 32'h0810_0005, 32'h0000_0000, 2'b11);
        wait_fv(1); check_frame("frame1", 32'h0810_0005, 32'h0810_0005, 2'b11);
        wait_fv(1); check_frame("frame2", 32'h0810_0015, 32'h0810_0005, 2'b11);
        wait_fv(1); check_frame("frame3", 32'h0810_0005, 32'h0810_0005, 2'b11);
        wait_fv(1); check_frame("frame4", 32'h0810_0045, 32'h0810_0005, 2'b11);
        wait_fv(1); check_frame("frame5", 32'h0810_0045, 32'h0810_0045, 2'b11);
        wait_fv(1); check_frame("frame6", 32'h0000_0045, 32'h0000_0045, 2'b01);
        wait_fv(1);
        wait_fv(10);

        // Data line stuck low: everyone disconnected
        stuck = 1'b1;
        wait_fv(1); check_frame("stuck", 32'h0, 32'h0, 2'b00);
        wait_fv(1);
        stuck = 1'b0;
        wait_fv(2);

        // Enable dropped while sampling bit 5
        wait_clk_falls(6);
        en = 1'b0;
        fv_seen   = 0;
        load_fell = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (fv_w[0]) fv_seen++;
            if (fv_seen > 0 && (jload_w != 2'b11)) load_fell = 1'b1;
        end
        check_eq("en_drop_fv_count", fv_seen, 1);
        check_eq("en_drop_load_fell", load_fell, 1'b0);
        check_idle_pins("idle");

        // Re-enable, then reset in the middle of a shift
        en = 1'b1;
        wait_fv(2);
        wait_clk_falls(9);
        #1 reset = 1'b1;
        #1 check_reset_state("async_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_fv(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
